dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the single-ported data memory (`datamemory`). It shares the memory between port 0, the core load/store unit, and port 1, the debug/DMA loader. Arbitration is round-robin. Each granted request runs through a fixed three-phase sequence: grant, memory access, response. Misaligned or illegal accesses are rejected before they reach the memory.

## Interface
- `DM_ADDRESS`, default 9: byte-address width presented to the data memory.
- `DATA_W`, default 32: data width.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `mN_req_valid` input 1 (N = 0, 1): request valid.
- `mN_req_ready` output 1: request accepted this cycle.
- `mN_req_we` input 1: 1 = store, 0 = load.
- `mN_req_addr` input DM_ADDRESS: byte address.
- `mN_req_wdata` input DATA_W: store data, unaligned (byte/half in the LSBs).
- `mN_req_funct3` input 3: RV32 load/store funct3.
- `mN_rsp_valid` output 1: response valid.
- `mN_rsp_ready` input 1: response consumed.
- `mN_rsp_rdata` output DATA_W: load result, 0 for stores and errors.
- `mN_rsp_err` output 1: access rejected (misaligned or illegal funct3).
- `MemRead` output 1: data memory read enable.
- `MemWrite` output 1: data memory write enable.
- `a` output DM_ADDRESS: memory address.
- `wd` output DATA_W: memory write data.
- `Funct3` output 3: memory access size/sign.
- `rd` input DATA_W: memory read data (combinational from `a`).

## Operation
- FSM states: IDLE, ACCESS, RESP. There is a single outstanding transaction across both ports.
- **IDLE**
  - If any `req_valid` is high, grant one port and pulse its `req_ready` for one cycle.
  - Latch `we`, `addr`, `wdata`, `funct3` and the owner port id.
  - Go to ACCESS.
- **Priority**
  - Round-robin on `last_grant`: the port not granted last wins when both are valid.
  - A single valid requester always wins.
- **Legality check** (computed at grant, stored as `err`):
  - funct3 000/100: any address.
  - funct3 001/101: `addr[0]` must be 0.
  - funct3 010: `addr[1:0]` must be 00.
  - funct3 011/110/111: always illegal.
  - Stores accept only 000/001/010; 100/101 with `we=1` is illegal.
- **ACCESS** (exactly one cycle)
  - Drive `a`, `wd`, `Funct3` from the latch.
  - `MemRead` = `!we & !err`; `MemWrite` = `we & !err`.
  - Capture `rd` into the response register at the end of the cycle.
  - Go to RESP.
- **RESP**
  - Assert the owner's `rsp_valid` with registered `rdata`/`err`.
  - Hold both stable until `rsp_ready`, then go to IDLE.
  - The non-owner's `rsp_valid` stays 0.
- **Outside ACCESS**: `MemRead` = `MemWrite` = 0, `a`/`wd`/`Funct3` = 0. All memory-side outputs are registered.
- An erroring transaction never asserts `MemRead`/`MemWrite`. Its `rsp_rdata` is 0.
- For stores, `rsp_rdata` is 0 and `rsp_err` = `err`.
- Requests arriving while not in IDLE see `req_ready` = 0 and must be held by the requester.

## Timing
- **Reset** (`rst_n` low at a rising edge):
  - State goes to IDLE; `last_grant` = 1, so port 0 wins first.
  - All outputs are 0 from the following cycle.
  - An in-flight transaction is dropped and no response is issued.
  - If reset lands in ACCESS, `MemWrite` is 0 from the next cycle. The store may or may not have committed.
- **Latency**: accept at cycle T (`req_ready` high), ACCESS at T+1, `rsp_valid` from T+2.
- **Throughput**: minimum 3 cycles per transaction. The next accept is possible in the cycle after the `rsp_ready` handshake.
- **Memory timing**: the data memory writes on the falling edge inside ACCESS. A load issued immediately after a store to the same word returns the new data.
- **Back-pressure**: `rsp_ready` held low keeps RESP indefinitely, and the other port is starved meanwhile (permitted).
- **Simultaneous requests** in IDLE: exactly one `req_ready` is asserted, never both.
- `last_grant` updates only on accept.

## Test plan
- **Store then load word**
  - Stimulus: port 0 stores SW 0xDEADBEEF @0x010, then loads LW @0x010.
  - Required: `rsp_rdata` = 0xDEADBEEF, `err` = 0, `rsp_valid` exactly 2 cycles after each accept.
- **Round-robin**
  - Stimulus: both ports hold LW requests continuously after reset.
  - Required: grants are 0, 1, 0, 1. With `rsp_ready` tied high, accepts are 3 cycles apart.
- **Misaligned and illegal**
  - Stimulus: LW @0x012, LH @0x003, funct3 = 011.
  - Required: each gives `rsp_err` = 1, `rsp_rdata` = 0, and `MemRead`/`MemWrite` never assert.
- **Byte sign extension**
  - Stimulus: SB 0x80 @0x021, then LB @0x021 and LBU @0x021.
  - Required: LB returns 0xFFFFFF80, LBU returns 0x00000080.
- **Back-pressure**
  - Stimulus: port 1 holds `rsp_ready` = 0 for 5 cycles while port 0 requests.
  - Required: port 1 `rsp_valid`/`rdata` stay stable and port 0 `req_ready` stays 0 throughout. Port 0 is accepted the cycle after port 1's handshake.
- **Reset mid-transaction**
  - Stimulus: `rst_n` low during ACCESS of a port 0 store.
  - Required: next cycle all outputs are 0 and no `rsp_valid` appears. After reset release, port 0 wins a simultaneous request.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer for the single-ported
// data memory. Port 0 is the core load/store unit. Port 1 is the debug/DMA loader.
// Each accepted request runs IDLE -> ACCESS -> RESP. Illegal or misaligned
// accesses are flagged at grant time and never reach the memory.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   mN_req_valid/ready       request handshake (ready pulses on accept)
//   mN_req_we/addr/wdata/funct3  request payload (wdata unaligned, in LSBs)
//   mN_rsp_valid/ready       response handshake (held until ready)
//   mN_rsp_rdata/err         load result (0 for stores/errors), reject flag
//   MemRead/MemWrite/a/wd/Funct3  registered data-memory controls, 0 outside ACCESS
//   rd                       data-memory read data (combinational from a)
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [DM_ADDRESS-1:0] m0_req_addr,
  input  logic [DATA_W-1:0]     m0_req_wdata,
  input  logic [2:0]            m0_req_funct3,
  output logic                  m0_rsp_valid,
  input  logic                  m0_rsp_ready,
  output logic [DATA_W-1:0]     m0_rsp_rdata,
  output logic                  m0_rsp_err,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [DM_ADDRESS-1:0] m1_req_addr,
  input  logic [DATA_W-1:0]     m1_req_wdata,
  input  logic [2:0]            m1_req_funct3,
  output logic                  m1_rsp_valid,
  input  logic                  m1_rsp_ready,
  output logic [DATA_W-1:0]     m1_rsp_rdata,
  output logic                  m1_rsp_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic                owner;
  logic                last_grant;
  logic                we_q;
  logic                err_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                grant_any;
  logic                grant_port;
  logic                sel_we;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [2:0]          sel_f3;
  logic                sel_err;
  logic                owner_rsp_ready;

  // Grant selection: with both ports valid, the one not granted last wins.
  always_comb begin
    grant_any  = m0_req_valid | m1_req_valid;
    grant_port = (m0_req_valid && m1_req_valid) ? ~last_grant : m1_req_valid;
    if (grant_port) begin
      sel_we    = m1_req_we;
      sel_addr  = m1_req_addr;
      sel_wdata = m1_req_wdata;
      sel_f3    = m1_req_funct3;
    end else begin
      sel_we    = m0_req_we;
      sel_addr  = m0_req_addr;
      sel_wdata = m0_req_wdata;
      sel_f3    = m0_req_funct3;
    end
  end

  // Legality: size/alignment, and stores cannot use the unsigned load encodings.
  always_comb begin
    sel_err = 1'b1;
    case (sel_f3)
      3'b000: sel_err = 1'b0;
      3'b100: sel_err = sel_we;
      3'b001: sel_err = sel_addr[0];
      3'b101: sel_err = sel_we | sel_addr[0];
      3'b010: sel_err = |sel_addr[1:0];
      default: sel_err = 1'b1;
    endcase
  end

  always_comb begin
    owner_rsp_ready = owner ? m1_rsp_ready : m0_rsp_ready;
    m0_req_ready    = rst_n && (state == IDLE) && grant_any && !grant_port;
    m1_req_ready    = rst_n && (state == IDLE) && grant_any &&  grant_port;
    m0_rsp_valid    = rsp_valid_q && !owner;
    m1_rsp_valid    = rsp_valid_q &&  owner;
    m0_rsp_err      = m0_rsp_valid & rsp_err_q;
    m1_rsp_err      = m1_rsp_valid & rsp_err_q;
    m0_rsp_rdata    = m0_rsp_valid ? rdata_q : '0;
    m1_rsp_rdata    = m1_rsp_valid ? rdata_q : '0;
  end

  // ACCESS lasts exactly one cycle, so the request latch for address, data and
  // size is the memory-side output register itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      a           <= '0;
      wd          <= '0;
      Funct3      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner      <= grant_port;
            last_grant <= grant_port;
            we_q       <= sel_we;
            err_q      <= sel_err;
            MemRead    <= !sel_we && !sel_err;
            MemWrite   <=  sel_we && !sel_err;
            a          <= sel_addr;
            wd         <= sel_wdata;
            Funct3     <= sel_f3;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          MemRead     <= 1'b0;
          MemWrite    <= 1'b0;
          a           <= '0;
          wd          <= '0;
          Funct3      <= '0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rdata_q     <= (we_q || err_q) ? '0 : rd;
          state       <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [8:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];
  logic        MemRead, MemWrite;
  logic [8:0]  a;
  logic [31:0] wd;
  logic [2:0]  Funct3;
  logic [31:0] rd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int memops = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(req_valid[0]), .m0_req_ready(req_ready[0]), .m0_req_we(req_we[0]),
    .m0_req_addr(req_addr[0]), .m0_req_wdata(req_wdata[0]), .m0_req_funct3(req_funct3[0]),
    .m0_rsp_valid(rsp_valid[0]), .m0_rsp_ready(rsp_ready[0]), .m0_rsp_rdata(rsp_rdata[0]),
    .m0_rsp_err(rsp_err[0]),
    .m1_req_valid(req_valid[1]), .m1_req_ready(req_ready[1]), .m1_req_we(req_we[1]),
    .m1_req_addr(req_addr[1]), .m1_req_wdata(req_wdata[1]), .m1_req_funct3(req_funct3[1]),
    .m1_rsp_valid(rsp_valid[1]), .m1_rsp_ready(rsp_ready[1]), .m1_rsp_rdata(rsp_rdata[1]),
    .m1_rsp_err(rsp_err[1]),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3), .rd(rd)
  );

  // Data memory model: writes on the falling edge, combinational sized read.
  logic [31:0] mem [128];
  logic [31:0] mword;
  logic [7:0]  mbyte;
  logic [15:0] mhalf;

  initial for (int i = 0; i < 128; i++) mem[i] = '0;

  always @(negedge clk) begin
    if (MemWrite) begin
      case (Funct3[1:0])
        2'b00:   mem[a[8:2]][{a[1:0], 3'b000} +: 8]  <= wd[7:0];
        2'b01:   mem[a[8:2]][{a[1], 4'b0000} +: 16] <= wd[15:0];
        default: mem[a[8:2]] <= wd;
      endcase
    end
  end

  always_comb begin
    mword = mem[a[8:2]];
    mbyte = mword[{a[1:0], 3'b000} +: 8];
    mhalf = mword[{a[1], 4'b0000} +: 16];
    case (Funct3)
      3'b000:  rd = {{24{mbyte[7]}}, mbyte};
      3'b100:  rd = {24'h0, mbyte};
      3'b001:  rd = {{16{mhalf[15]}}, mhalf};
      3'b101:  rd = {16'h0, mhalf};
      default: rd = mword;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (MemRead || MemWrite) memops <= memops + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, {22'h0, req_ready[0], req_ready[1], rsp_valid[0], rsp_valid[1],
                          rsp_err[0], rsp_err[1], MemRead, MemWrite}, 32'h0);
    check({tag, "_mem"}, {20'h0, Funct3, a}, 32'h0);
    check({tag, "_wd"}, wd, 32'h0);
    check({tag, "_rdata"}, rsp_rdata[0] | rsp_rdata[1], 32'h0);
  endtask

  // One complete transaction on port p; lat is cycles from accept to first rsp_valid.
  task automatic xact(input int p, input logic we, input logic [8:0] ad, input logic [31:0] wdat,
                      input logic [2:0] f3, output logic [31:0] rdat, output logic er,
                      output int lat);
    int  t_acc, t_rsp;
    bit  got;
    rdat = '0; er = 1'b0; lat = -1; t_acc = 0; t_rsp = 0;
    req_we[p] = we; req_addr[p] = ad; req_wdata[p] = wdat; req_funct3[p] = f3;
    req_valid[p] = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin got = 1; t_acc = cyc; end
    end
    @(posedge clk); #1 req_valid[p] = 1'b0;
    if (!got) begin check("accept_timeout", 0, 1); return; end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[p]) begin got = 1; t_rsp = cyc; rdat = rsp_rdata[p]; er = rsp_err[p]; end
    end
    if (!got) begin check("rsp_timeout", 0, 1); return; end
    rsp_ready[p] = 1'b1;
    @(posedge clk); #1 rsp_ready[p] = 1'b0;
    lat = t_rsp - t_acc;
  endtask

  logic [31:0] r;
  logic        e;
  int          lat, m_before, t_hs, ng;
  int          gport [4];
  int          gcyc  [4];
  int          both_seen;
  bit          got;

  initial begin
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 0; req_we[p] = 0; req_addr[p] = '0; req_wdata[p] = '0;
      req_funct3[p] = '0; rsp_ready[p] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Round-robin: both ports hold LW requests, responses always consumed.
    req_funct3[0] = 3'b010; req_addr[0] = 9'h010;
    req_funct3[1] = 3'b010; req_addr[1] = 9'h014;
    rsp_ready[0] = 1; rsp_ready[1] = 1;
    req_valid[0] = 1; req_valid[1] = 1;
    ng = 0; both_seen = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (req_ready[0] && req_ready[1]) both_seen++;
      if (req_ready[0] || req_ready[1]) begin
        gport[ng] = req_ready[1] ? 1 : 0;
        gcyc[ng]  = cyc;
        ng++;
      end
    end
    @(posedge clk); #1 req_valid[0] = 0; req_valid[1] = 0;
    repeat (4) @(posedge clk);
    #1 rsp_ready[0] = 0; rsp_ready[1] = 0;
    check("rr_count", ng, 4);
    check("rr_both_ready", both_seen, 0);
    check("rr_g0", gport[0], 0);
    check("rr_g1", gport[1], 1);
    check("rr_g2", gport[2], 0);
    check("rr_g3", gport[3], 1);
    for (int i = 1; i < 4; i++) check("rr_gap", gcyc[i] - gcyc[i-1], 3);

    // Store then load word.
    xact(0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, r, e, lat);
    check("sw_rdata", r, 32'h0);
    check("sw_err", e, 0);
    check("sw_lat", lat, 2);
    m_before = memops;
    xact(0, 1'b0, 9'h010, 32'h0, 3'b010, r, e, lat);
    check("lw_rdata", r, 32'hDEADBEEF);
    check("lw_err", e, 0);
    check("lw_lat", lat, 2);
    check("lw_memops", memops - m_before, 1);

    // Misaligned and illegal accesses.
    m_before = memops;
    xact(0, 1'b0, 9'h012, 32'h0, 3'b010, r, e, lat);
    check("lw_mis_err", e, 1);
    check("lw_mis_rdata", r, 32'h0);
    xact(1, 1'b0, 9'h003, 32'h0, 3'b001, r, e, lat);
    check("lh_mis_err", e, 1);
    check("lh_mis_rdata", r, 32'h0);
    xact(0, 1'b0, 9'h010, 32'h0, 3'b011, r, e, lat);
    check("f3_011_err", e, 1);
    check("f3_011_rdata", r, 32'h0);
    xact(1, 1'b1, 9'h010, 32'h11111111, 3'b100, r, e, lat);
    check("st_100_err", e, 1);
    check("illegal_memops", memops - m_before, 0);
    xact(1, 1'b0, 9'h010, 32'h0, 3'b010, r, e, lat);
    check("word_untouched", r, 32'hDEADBEEF);

    // Byte store and sign/zero-extended loads.
    xact(0, 1'b1, 9'h021, 32'h00000080, 3'b000, r, e, lat);
    check("sb_err", e, 0);
    xact(0, 1'b0, 9'h021, 32'h0, 3'b000, r, e, lat);
    check("lb_rdata", r, 32'hFFFFFF80);
    xact(1, 1'b0, 9'h021, 32'h0, 3'b100, r, e, lat);
    check("lbu_rdata", r, 32'h00000080);
    check("lbu_lat", lat, 2);

    // Back-pressure: port 1 response stalls while port 0 waits.
    req_we[1] = 0; req_addr[1] = 9'h010; req_funct3[1] = 3'b010; req_valid[1] = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (req_ready[1]) got = 1; end
    check("bp_acc1", got, 1);
    @(posedge clk); #1 req_valid[1] = 0;
    req_we[0] = 0; req_addr[0] = 9'h020; req_funct3[0] = 3'b010; req_valid[0] = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (rsp_valid[1]) got = 1; end
    check("bp_rsp1", got, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid1", rsp_valid[1], 1);
      check("bp_rdata1", rsp_rdata[1], 32'hDEADBEEF);
      check("bp_ready0", req_ready[0], 0);
      @(negedge clk);
    end
    rsp_ready[1] = 1; t_hs = cyc;
    @(posedge clk); #1 rsp_ready[1] = 0;
    @(negedge clk);
    check("bp_acc0", req_ready[0], 1);
    check("bp_acc0_cyc", cyc - t_hs, 1);
    @(posedge clk); #1 req_valid[0] = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (rsp_valid[0]) got = 1; end
    check("bp_lw_word", rsp_rdata[0], 32'h00008000);
    rsp_ready[0] = 1;
    @(posedge clk); #1 rsp_ready[0] = 0;

    // Reset during ACCESS of a port 0 store.
    req_we[0] = 1; req_addr[0] = 9'h030; req_wdata[0] = 32'h12345678;
    req_funct3[0] = 3'b010; req_valid[0] = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (req_ready[0]) got = 1; end
    @(posedge clk); #1 req_valid[0] = 0;
    @(negedge clk);
    check("rst_access_we", MemWrite, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    @(negedge clk);
    check("midrst_rsp0", rsp_valid[0], 0);
    req_we[0] = 0; req_addr[0] = 9'h010; req_funct3[0] = 3'b010;
    req_we[1] = 0; req_addr[1] = 9'h014; req_funct3[1] = 3'b010;
    req_valid[0] = 1; req_valid[1] = 1; rst_n = 1'b1;
    #1;
    check("post_rst_ready0", req_ready[0], 1);
    check("post_rst_ready1", req_ready[1], 0);
    @(posedge clk); #1 req_valid[0] = 0; req_valid[1] = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (rsp_valid[0]) got = 1; end
    check("post_rst_rsp0", got, 1);
    check("post_rst_rdata0", rsp_rdata[0], 32'hDEADBEEF);
    rsp_ready[0] = 1;
    @(posedge clk); #1 rsp_ready[0] = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
